alu64_sequencer: RTL
====================

# alu64_sequencer

Multi-cycle initiator for the 32-bit combinational ALU. It accepts a 64-bit operation request over a valid/ready handshake and issues it to the ALU as two 32-bit passes: low word first, then high word with the carry chained. It combines the per-pass flags and returns a registered 64-bit result on a valid/ready response channel. It sits between the datapath controller and the ALU instance and drives every ALU input.

## Interface
- `W`, default 32: ALU word width. The operand width is `2*W`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 2: operation (encoding in Operation).
- `req_a`, `req_b` in 2W: operands.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_out` out 2W: result.
- `rsp_cout` out 1: carry out of bit 2W-1. Always 0 for logic ops.
- `rsp_zout` out 1: full 64-bit result is zero.
- `rsp_ovf` out 1: signed overflow. Always 0 for logic ops.
- `alu_a`, `alu_b` out W: ALU operands.
- `alu_carryin`, `alu_s0`, `alu_s1` out 1: ALU carry-in and op select.
- `alu_out` in W, `alu_cout` in 1, `alu_zout` in 1: ALU results, valid in the same cycle the inputs are driven.

## Operation
- Op encoding `{s1,s0}`: 00 ADD, 01 SUB (the ALU inverts b; the sequencer supplies carry-in 1), 10 AND, 11 OR.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: `req_ready`=1. On `req_valid`, latch op, a and b, then go to LO.
  - LO: drive the low words. `alu_carryin` is 1 for SUB and 0 otherwise. Register `alu_out` as the low result, `alu_cout` as the chained carry, and `alu_zout` as the low-zero flag. Go to HI.
  - HI: drive the high words. `alu_carryin` is the registered LO carry for ADD/SUB and 0 for AND/OR. Register the high result, final cout, and `zout` = low-zero AND `alu_zout`. Compute `ovf`:
    - ADD: a[63]==b[63] and r[63]!=a[63].
    - SUB: a[63]!=b[63] and r[63]!=a[63].
    - Go to DONE.
  - DONE: `rsp_valid`=1. Hold all `rsp_*` stable until `rsp_ready`, then go to IDLE.
- `alu_s0`/`alu_s1` come from the latched op in LO and HI, and are 0 in IDLE and DONE.
- `alu_a`, `alu_b` and `alu_carryin` are 0 in IDLE and DONE. The ALU therefore sees quiet inputs outside the two passes.
- There is no request queue. Requests offered while `req_ready`=0 wait upstream.
- Reset:
  - Values: state IDLE; `req_ready`=1 after reset; `rsp_valid`=0; `rsp_out`=0; `rsp_cout`=`rsp_zout`=`rsp_ovf`=0; all `alu_*` outputs 0.
  - Reset in any state, including mid-pass or DONE with a pending response, drops the operation and returns to IDLE. No response is produced.

## Timing
- Request handshake cycle is T. LO pass runs in T+1, HI pass in T+2, and `rsp_valid` rises in T+3. Latency is 3 cycles.
- A response accepted in cycle D gives `req_ready`=1 in D+1. Best-case throughput is one operation per 4 cycles.
- `req_ready` and `rsp_valid` are never both 1.
- The ALU is combinational with a single-cycle path. Results are sampled on the same edge that ends each pass.
- All outputs are registered except the `alu_*` drive, which is decoded from registered state and latched operands.

## Structure
- Shared package `alu_pkg`:
  - op encoding constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`;
  - state typedef `seq_state_t`;
  - `W` default.
- One natural sub-module: `alu_flag_merge`, which combines the per-pass zero, carry and sign bits into `zout`/`cout`/`ovf`. Everything else stays in the top level.
- The ALU itself is instantiated outside this block. For verification, the bench instantiates `alu32` (or a behavioural model of it) on the `alu_*` ports.

## Test plan
- Carry chain: ADD a=0x00000000_FFFFFFFF, b=0x1. Response 3 cycles after accept: out=0x00000001_00000000, cout=0, zout=0, ovf=0. The HI pass shows `alu_carryin`=1.
- Zero result: SUB a=b=0x12345678_9ABCDEF0. Expect out=0, zout=1, cout=1, ovf=0.
- Signed overflow: ADD a=0x7FFFFFFF_FFFFFFFF, b=0x1. Expect out=0x80000000_00000000, ovf=1, cout=0.
- Logic op: AND a=0xFFFF0000_FFFF0000, b=0x0F0F0F0F_0F0F0F0F. Expect out=0x0F0F0000_0F0F0000, cout=0, ovf=0. `alu_carryin`=0 in both passes.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in DONE.
  - `rsp_*` stay stable and `req_ready` stays 0.
  - A new request offered during the stall is accepted only in the cycle after `rsp_ready`=1.
- Reset mid-op: assert `rst_n`=0 during HI. Next cycle: state IDLE, `rsp_valid`=0, `req_ready`=1, all `alu_*` outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit sequencer around the 32-bit ALU:
// op encodings, sequencer states and the default ALU word width.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } seq_state_t;

  function automatic logic op_is_arith(input logic [1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_flag_merge.sv
// Folds the low-pass zero flag and the high-pass ALU results into the
// 64-bit zero, carry-out and signed-overflow flags.
module alu_flag_merge
  import alu_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic       lo_zero_i,
  input  logic       hi_zero_i,
  input  logic       hi_cout_i,
  input  logic       a_msb_i,
  input  logic       b_msb_i,
  input  logic       r_msb_i,
  output logic       zout_o,
  output logic       cout_o,
  output logic       ovf_o
);

  always_comb begin
    zout_o = lo_zero_i & hi_zero_i;
    cout_o = 1'b0;
    ovf_o  = 1'b0;
    if (op_is_arith(op_i)) begin
      cout_o = hi_cout_i;
      // SUB adds ~b, so overflow needs operands of differing sign
      if (op_i == ALU_ADD) begin
        ovf_o = (a_msb_i == b_msb_i) && (r_msb_i != a_msb_i);
      end else begin
        ovf_o = (a_msb_i != b_msb_i) && (r_msb_i != a_msb_i);
      end
    end
  end

endmodule

// File: rtl/alu64_sequencer.sv
// Runs a 64-bit request through the 32-bit combinational ALU as a low
// pass and a carry-chained high pass, returning a registered response.
module alu64_sequencer
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_out,
  output logic           rsp_cout,
  output logic           rsp_zout,
  output logic           rsp_ovf,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_carryin,
  output logic           alu_s0,
  output logic           alu_s1,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_cout,
  input  logic           alu_zout
);

  seq_state_t     state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] b_q, b_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           carry_q, carry_d;
  logic           lo_zero_q, lo_zero_d;
  logic [2*W-1:0] rsp_out_q, rsp_out_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_zout_q, rsp_zout_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           mrg_zout, mrg_cout, mrg_ovf;

  alu_flag_merge u_flag_merge (
    .op_i      (op_q),
    .lo_zero_i (lo_zero_q),
    .hi_zero_i (alu_zout),
    .hi_cout_i (alu_cout),
    .a_msb_i   (a_q[2*W-1]),
    .b_msb_i   (b_q[2*W-1]),
    .r_msb_i   (alu_out[W-1]),
    .zout_o    (mrg_zout),
    .cout_o    (mrg_cout),
    .ovf_o     (mrg_ovf)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    lo_d       = lo_q;
    carry_d    = carry_q;
    lo_zero_d  = lo_zero_q;
    rsp_out_d  = rsp_out_q;
    rsp_cout_d = rsp_cout_q;
    rsp_zout_d = rsp_zout_q;
    rsp_ovf_d  = rsp_ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_LO;
        end
      end
      S_LO: begin
        lo_d      = alu_out;
        carry_d   = alu_cout;
        lo_zero_d = alu_zout;
        state_d   = S_HI;
      end
      S_HI: begin
        rsp_out_d  = {alu_out, lo_q};
        rsp_cout_d = mrg_cout;
        rsp_zout_d = mrg_zout;
        rsp_ovf_d  = mrg_ovf;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake flags are registered copies of the next state
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_carryin = 1'b0;
    alu_s0      = 1'b0;
    alu_s1      = 1'b0;
    unique case (state_q)
      S_LO: begin
        alu_a       = a_q[W-1:0];
        alu_b       = b_q[W-1:0];
        alu_carryin = (op_q == ALU_SUB);
        alu_s0      = op_q[0];
        alu_s1      = op_q[1];
      end
      S_HI: begin
        alu_a       = a_q[2*W-1:W];
        alu_b       = b_q[2*W-1:W];
        alu_carryin = op_is_arith(op_q) & carry_q;
        alu_s0      = op_q[0];
        alu_s1      = op_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      lo_q        <= '0;
      carry_q     <= 1'b0;
      lo_zero_q   <= 1'b0;
      rsp_out_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_zout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lo_q        <= lo_d;
      carry_q     <= carry_d;
      lo_zero_q   <= lo_zero_d;
      rsp_out_q   <= rsp_out_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_zout_q  <= rsp_zout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zout  = rsp_zout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule
